teclado_ps2: RTL and testbench
==============================

# teclado_ps2

PS/2 keyboard front end for FPGAudio. Deserialises frames from the keyboard's `ps2_clk`/`ps2_data` lines and decodes Set-2 make/break/extended scancodes. It drives the `right_arrow_pressed`, `left_arrow_pressed` and `enter_pressed` level inputs of the data path, which feed the menu and the enter edge detector. It sits directly upstream of the data path, alongside the button debouncer.

## Interface
Parameters:
- `CLOCK_FREQ`, 50_000_000: system clock frequency in Hz.
- `FILTRO`, 8: cycles that synchronised `ps2_clk` must hold stable before the filtered value changes.
- `TIMEOUT_US`, 2000: maximum gap in µs between falling edges inside one frame. Timeout cycles are `CLOCK_FREQ/1_000_000*TIMEOUT_US`.

Ports:
- `clock` in 1: system clock; every register is on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `ps2_clk` in 1: raw keyboard clock, asynchronous to `clock`.
- `ps2_data` in 1: raw keyboard data, asynchronous to `clock`.
- `right_arrow_pressed` out 1: level, 1 while the right arrow is held.
- `left_arrow_pressed` out 1: level, 1 while the left arrow is held.
- `enter_pressed` out 1: level, 1 while Enter or keypad Enter is held.
- `byte_valido` out 1: one-cycle pulse for each accepted byte.
- `erro_paridade` out 1: one-cycle pulse for each frame dropped on parity.
- `db_scancode` out 8: last accepted byte, for debug.

## Operation
- **Input conditioning:**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - The synchronised clock goes through a stability filter: the filtered value takes the new level after `FILTRO` consecutive equal samples.
  - A falling edge of the filtered clock samples synchronised `ps2_data`.
- **Frame:** 11 bits in this order:
  - start = 0;
  - d0..d7, LSB first;
  - odd parity;
  - stop = 1.
- **Receiver FSM:**
  - `OCIOSO`: on a falling edge with data=0, go to `DADOS` with bit count 0. On a falling edge with data=1, stay (glitch, ignored).
  - `DADOS`: shift in 8 bits, then go to `PARIDADE`.
  - `PARIDADE`: store the parity bit, then go to `PARADA`.
  - `PARADA`: on the next edge, if stop=1 and the parity check passes, assert `byte_valido` for one cycle. In all cases, return to `OCIOSO`.
- **Timeout:** the timer resets on every falling edge. In any state other than `OCIOSO`, expiry returns the FSM to `OCIOSO`, discards the partial byte and emits no pulse.
- **Decoder:** acts on each `byte_valido`.
  - `0xE0` sets `ext`. `0xF0` sets `brk`. Neither changes the outputs.
  - Any other byte forms a code from (`ext`, byte):
    - E0 74 → right arrow;
    - E0 6B → left arrow;
    - 5A or E0 5A → enter.
  - `brk`=0 sets the matching output to 1; `brk`=1 clears it to 0.
  - `ext` and `brk` clear after every non-prefix byte, whether the code is recognised or not.
- **Boundary cases:**
  - Unrecognised codes leave all outputs unchanged.
  - Typematic repeat of a make code keeps the level at 1.
  - A break for a key that is not held has no effect.
  - Outputs are independent; both arrows may be 1 at once.
  - A dropped frame (parity or timeout) does not clear `ext`/`brk`.
- **Reset:** asynchronous, any time including mid-frame. Afterwards: FSM in `OCIOSO`, `ext`=`brk`=0, all outputs 0, `db_scancode`=0x00, filter output = 1 (idle line).

## Timing
- Edge-detect latency: a raw `ps2_clk` fall is seen as a filtered falling edge 2 (sync) + `FILTRO` cycles later, ±1.
- The `byte_valido` pulse occurs in the cycle after the stop-bit falling edge is detected. `db_scancode` updates in that same cycle.
- Level outputs change exactly 1 cycle after the `byte_valido` pulse of the final byte of the sequence.
- `erro_paridade` occurs in the same cycle slot as `byte_valido` would have.
- The keyboard clock runs at 10–16.7 kHz, so at least about 3000 `clock` cycles separate edges at 50 MHz. No backpressure and no handshake.

## Configuration
- `TECLADO_PS2_PARITY_EN` defined: odd parity is checked. A failing frame is dropped and `erro_paridade` pulses.
- Not defined: the parity bit is received and ignored, and `erro_paridade` is tied to 0.
- The stop bit is checked in both builds.

## Structure
- Package `teclado_ps2_pkg`:
  - scancode constants `SC_EXT`=8'hE0, `SC_BREAK`=8'hF0, `SC_ENTER`=8'h5A, `SC_RIGHT`=8'h74, `SC_LEFT`=8'h6B;
  - receiver state enum (`OCIOSO`, `DADOS`, `PARIDADE`, `PARADA`).
- Sub-module `ps2_receptor_quadro`: synchroniser, filter, FSM and timeout. It outputs the byte, `byte_valido` and `erro_paridade`.
- The top-level holds the decoder and the output registers.

## Test plan
- Frame 0x5A (parity 1), then F0, then 5A → `enter_pressed` goes 0→1 one cycle after the first `byte_valido`; after the third byte it returns to 0.
- E0 74, E0 6B, then E0 F0 74 → both arrows go to 1; after the last byte, right arrow is 0 and left arrow stays 1.
- Frame 0x74 with parity 0 (wrong), parity check enabled → `erro_paridade` pulses once, no `byte_valido`, outputs unchanged. With the macro undefined, `byte_valido` pulses and `db_scancode`=0x74.
- Send 5 bits, then hold `ps2_clk` high for > `TIMEOUT_US` → no pulse. A following valid 0x5A frame is decoded correctly.
- Assert `reset` mid-frame while `enter_pressed`=1 → all outputs 0 immediately, `db_scancode`=0. The next full frame decodes normally.
- Inject 3-cycle low glitches on `ps2_clk` while idle (`FILTRO`=8) → no edge detected, FSM stays `OCIOSO`.

Source files
------------

// File: rtl/teclado_ps2_pkg.sv
// Shared scancode constants and receiver state encoding for the PS/2 keyboard front end.
package teclado_ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    DADOS    = 2'd1,
    PARIDADE = 2'd2,
    PARADA   = 2'd3
  } estado_t;

endpackage

// File: rtl/ps2_receptor_quadro.sv
// PS/2 frame receiver: input synchronisers, ps2_clk glitch filter, frame FSM and inter-edge timeout.
// Odd parity is checked only when TECLADO_PS2_PARITY_EN is defined.
module ps2_receptor_quadro
  import teclado_ps2_pkg::*;
#(
  parameter int FILTRO      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_o,
  output logic       byte_valido,
  output logic       erro_paridade
);

  localparam int FW = $clog2(FILTRO + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_q, fall_d;
  logic [TW-1:0] timer_q, timer_d;
  estado_t       state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          dat;
  logic          par_ok;

  assign dat = dat_sync_q[1];

`ifdef TECLADO_PS2_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  assign par_ok = ^{par_q, shift_q};
  assign erro_paridade = perr_q;
`else
  assign par_ok = 1'b1;
  assign erro_paridade = 1'b0;
`endif

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    filt_d     = filt_q;
    fcnt_d     = '0;
    timer_d    = timer_q;
    state_d    = state_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    valid_d    = 1'b0;
`ifdef TECLADO_PS2_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif

    // Filtered level flips only after FILTRO consecutive samples at the new level.
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILTRO - 1)) filt_d = clk_sync_q[1];
      else                           fcnt_d = fcnt_q + 1'b1;
    end
    fall_d = filt_q & ~filt_d;

    if (fall_q)                               timer_d = '0;
    else if (timer_q != TW'(TIMEOUT_CYC))     timer_d = timer_q + 1'b1;

    if (fall_q) begin
      case (state_q)
        OCIOSO: if (!dat) begin
          state_d = DADOS;
          bit_d   = 3'd0;
        end
        DADOS: begin
          shift_d = {dat, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARIDADE;
        end
        PARIDADE: begin
`ifdef TECLADO_PS2_PARITY_EN
          par_d   = dat;
`endif
          state_d = PARADA;
        end
        PARADA: begin
          state_d = OCIOSO;
          if (dat) begin
            if (par_ok) begin
              valid_d = 1'b1;
              byte_d  = shift_q;
            end
`ifdef TECLADO_PS2_PARITY_EN
            else perr_d = 1'b1;
`endif
          end
        end
        default: state_d = OCIOSO;
      endcase
    end else if (state_q != OCIOSO && timer_q == TW'(TIMEOUT_CYC)) begin
      state_d = OCIOSO;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      fall_q     <= 1'b0;
      timer_q    <= '0;
      state_q    <= OCIOSO;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      byte_q     <= 8'h00;
      valid_q    <= 1'b0;
`ifdef TECLADO_PS2_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      fall_q     <= fall_d;
      timer_q    <= timer_d;
      state_q    <= state_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
`ifdef TECLADO_PS2_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign byte_o      = byte_q;
  assign byte_valido = valid_q;

endmodule

// File: rtl/teclado_ps2.sv
// PS/2 keyboard front end: frame receiver plus Set-2 make/break/extended decoder for arrows and Enter.
// Optional build macro TECLADO_PS2_PARITY_EN enables odd parity checking in the receiver.
module teclado_ps2
  import teclado_ps2_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int FILTRO     = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       right_arrow_pressed,
  output logic       left_arrow_pressed,
  output logic       enter_pressed,
  output logic       byte_valido,
  output logic       erro_paridade,
  output logic [7:0] db_scancode
);

  localparam int TIMEOUT_CYC = CLOCK_FREQ / 1_000_000 * TIMEOUT_US;

  logic [7:0] rx_byte;
  logic       rx_valid;

  ps2_receptor_quadro #(
    .FILTRO      (FILTRO),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clock         (clock),
    .reset         (reset),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .byte_o        (rx_byte),
    .byte_valido   (rx_valid),
    .erro_paridade (erro_paridade)
  );

  logic ext_q, ext_d;
  logic brk_q, brk_d;
  logic right_q, right_d;
  logic left_q, left_d;
  logic enter_q, enter_d;

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    right_d = right_q;
    left_d  = left_q;
    enter_d = enter_q;
    if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        // Enter and keypad Enter share the same base code; prefix does not matter.
        if (rx_byte == SC_ENTER)          enter_d = ~brk_q;
        if (ext_q && rx_byte == SC_RIGHT) right_d = ~brk_q;
        if (ext_q && rx_byte == SC_LEFT)  left_d  = ~brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      right_q <= 1'b0;
      left_q  <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      right_q <= right_d;
      left_q  <= left_d;
      enter_q <= enter_d;
    end
  end

  assign right_arrow_pressed = right_q;
  assign left_arrow_pressed  = left_q;
  assign enter_pressed       = enter_q;
  assign byte_valido         = rx_valid;
  assign db_scancode         = rx_byte;

endmodule

// File: tb/tb_teclado_ps2.sv
// Scoreboard bench for teclado_ps2: frames are generated bit by bit, expectations come from a keyboard-level model.
module tb_teclado_ps2;

  localparam int HALF = 30;
  localparam int GAP  = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       right_arrow_pressed, left_arrow_pressed, enter_pressed;
  logic       byte_valido, erro_paridade;
  logic [7:0] db_scancode;

  teclado_ps2 #(.CLOCK_FREQ(1_000_000), .FILTRO(8), .TIMEOUT_US(400)) dut (
    .clock               (clock),
    .reset               (reset),
    .ps2_clk             (ps2_clk),
    .ps2_data            (ps2_data),
    .right_arrow_pressed (right_arrow_pressed),
    .left_arrow_pressed  (left_arrow_pressed),
    .enter_pressed       (enter_pressed),
    .byte_valido         (byte_valido),
    .erro_paridade       (erro_paridade),
    .db_scancode         (db_scancode)
  );

  always #5 clock = ~clock;

  // levels packed as {right, left, enter}
  typedef struct {
    bit         err;
    logic [7:0] b;
    logic [2:0] pre;
    logic [2:0] post;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  bit         m_ext = 0, m_brk = 0;
  logic [2:0] m_lv = 3'b000;

  function automatic logic [2:0] levels();
    return {right_arrow_pressed, left_arrow_pressed, enter_pressed};
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // Keyboard-level model: what a host should conclude after each accepted byte.
  task automatic model_push(input logic [7:0] b, input bit err);
    exp_t e;
    e.err = err;
    e.b   = b;
    e.pre = m_lv;
    if (!err) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        if (b == 8'h5A) m_lv[0] = !m_brk;
        if (m_ext && b == 8'h74) m_lv[2] = !m_brk;
        if (m_ext && b == 8'h6B) m_lv[1] = !m_brk;
        m_ext = 0;
        m_brk = 0;
      end
    end
    e.post = m_lv;
    sbq.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Sends the first nbits of a frame; only complete frames produce an expectation.
  task automatic send_frame(input logic [7:0] b, input bit badpar, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, ~(^b) ^ badpar, b, 1'b0};
    if (nbits == 11) begin
`ifdef TECLADO_PS2_PARITY_EN
      model_push(b, badpar);
`else
      model_push(b, 1'b0);
`endif
    end
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  // Monitor: pops one expectation per pulse, checks levels before and one cycle after.
  bit         pend = 0;
  logic [2:0] pend_post;
  always @(negedge clock) begin
    if (!reset) begin
      if (byte_valido || erro_paridade) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got valid=%0b perr=%0b expected none", byte_valido, erro_paridade);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("pulse_valid", byte_valido, !e.err);
          check("pulse_perr", erro_paridade, e.err);
          if (!e.err) check("db_scancode", db_scancode, e.b);
          check("levels_pre", levels(), e.pre);
          pend      = 1;
          pend_post = e.post;
        end
      end else if (pend) begin
        check("levels_post", levels(), pend_post);
        pend = 0;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] pool [6];
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h5A;
    pool[3] = 8'h74; pool[4] = 8'h6B; pool[5] = 8'h00;

    #1;
    check("rst_levels", levels(), 3'b000);
    check("rst_db", db_scancode, 8'h00);
    check("rst_valid", byte_valido, 1'b0);
    check("rst_perr", erro_paridade, 1'b0);
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(20);

    // Enter make, break
    send(8'h5A); send(8'hF0); send(8'h5A);
    // both arrows, then release right only
    send(8'hE0); send(8'h74); send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h74);
    // wrong parity frame
    send_frame(8'h74, 1'b1, 11);
    // typematic repeat of left arrow
    send(8'hE0); send(8'h6B);
    // partial frame abandoned, then a good frame
    send_frame(8'h74, 1'b0, 5);
    wait_cyc(600);
    send(8'h5A);
    // short glitches while idle must not start a frame
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    send(8'hF0); send(8'h5A);
    // reset mid-frame with enter held
    send(8'h5A);
    send_frame(8'h6B, 1'b0, 4);
    reset = 1'b1;
    #1;
    check("midrst_levels", levels(), 3'b000);
    check("midrst_db", db_scancode, 8'h00);
    m_ext = 0; m_brk = 0; m_lv = 3'b000;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(20);
    send(8'hE0); send(8'h74);

    for (int r = 0; r < 40; r++) begin
      logic [7:0] b;
      b = pool[$urandom_range(0, 5)];
      if (b == 8'h00) b = 8'($urandom);
      send_frame(b, ($urandom_range(0, 7) == 0), 11);
    end

    wait_cyc(100);
    check("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
